// File: rtl/shift_pkg.sv
// Shared types and constants for the shift decode/issue stage.
package shift_pkg;

    localparam int unsigned DW    = 32;
    localparam int unsigned SH_W  = 5;
    localparam int unsigned REG_W = 5;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;

    localparam logic [1:0] ALUC_SRA = 2'b00;
    localparam logic [1:0] ALUC_SLL = 2'b01;
    localparam logic [1:0] ALUC_SRL = 2'b10;

    typedef struct packed {
        logic [DW-1:0]    a;
        logic [SH_W-1:0]  b;
        logic [1:0]       aluc;
        logic [REG_W-1:0] dst;
    } shift_op_t;

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready is a pure register output.
module skid_buf
    import shift_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      in_valid,
    output logic      in_ready,
    input  shift_op_t in_data,
    output logic      out_valid,
    input  logic      out_ready,
    output shift_op_t out_data
);

    logic      r_main_valid;
    logic      r_skid_valid;
    shift_op_t r_main;
    shift_op_t r_skid;

    logic w_push;
    logic w_pop;

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main;
    assign w_push    = in_valid && !r_skid_valid;
    assign w_pop     = r_main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_pop) begin
            // Main slot frees up: refill from skid first to keep FIFO order.
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_push) begin
                r_main       <= in_data;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_push) begin
            r_skid       <= in_data;
            r_skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/shift_issue_stage.sv
// Decodes MIPS shift instructions for the barrel shifter and issues them through a skid buffer.
module shift_issue_stage
    import shift_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_instr,
    input  logic [DW-1:0]    in_rs_val,
    input  logic [DW-1:0]    in_rt_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_a,
    output logic [SH_W-1:0]  out_b,
    output logic [1:0]       out_aluc,
    output logic [REG_W-1:0] out_dst,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_is_shift;
    logic       w_accept;
    logic       w_ready;
    shift_op_t  w_dec;
    shift_op_t  w_out;

    logic [CNT_W-1:0] r_drop_cnt;

    assign w_op    = in_instr[31:26];
    assign w_funct = in_instr[5:0];

    always_comb begin
        w_is_shift = 1'b0;
        w_dec.a    = in_rt_val;
        w_dec.b    = in_instr[10:6];
        w_dec.aluc = ALUC_SLL;
        w_dec.dst  = in_instr[15:11];
        if (w_op == 6'd0) begin
            unique case (w_funct)
                F_SLL:  begin w_is_shift = 1'b1; w_dec.aluc = ALUC_SLL; end
                F_SRL:  begin w_is_shift = 1'b1; w_dec.aluc = ALUC_SRL; end
                F_SRA:  begin w_is_shift = 1'b1; w_dec.aluc = ALUC_SRA; end
                F_SLLV: begin
                    w_is_shift = 1'b1;
                    w_dec.aluc = ALUC_SLL;
                    w_dec.b    = in_rs_val[4:0];
                end
                F_SRLV: begin
                    w_is_shift = 1'b1;
                    w_dec.aluc = ALUC_SRL;
                    w_dec.b    = in_rs_val[4:0];
                end
                F_SRAV: begin
                    w_is_shift = 1'b1;
                    w_dec.aluc = ALUC_SRA;
                    w_dec.b    = in_rs_val[4:0];
                end
                default: w_is_shift = 1'b0;
            endcase
        end
    end

    // A flushed cycle discards the handshake entirely, including drop accounting.
    assign w_accept = in_valid && w_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_is_shift) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    skid_buf u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (w_accept && w_is_shift),
        .in_ready  (w_ready),
        .in_data   (w_dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out)
    );

    assign in_ready = w_ready;
    assign out_a    = w_out.a;
    assign out_b    = w_out.b;
    assign out_aluc = w_out.aluc;
    assign out_dst  = w_out.dst;
    assign drop_cnt = r_drop_cnt;

endmodule
